cpu_memory: RTL and testbench
=============================

Name: cpu_memory

Overview:
- Memory stage of the mox125 pipeline, directly downstream of the execute stage, upstream of writeback.
- Consumes execute results: address, store data, register results and write indices. Performs data loads and stores over a 16-bit big-endian Wishbone master.
- Splits 32-bit accesses into two 16-bit beats and holds the upstream stage with `stall_o` while a bus access is in flight.

Parameters:
- `ADDR_W`, 32: data address width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  execute presents an instruction this cycle.
- `mem_rd_i`  in  1  instruction is a load.
- `mem_wr_i`  in  1  instruction is a store (`mem_rd_i` and `mem_wr_i` both set: treated as load).
- `mem_size_i`  in  2  access size: 00 byte, 01 short, 10 long, 11 treated as long.
- `memory_address_i`  in  32  effective address.
- `mem_data_i`  in  32  store data.
- `reg0_result_i`, `reg1_result_i`  in  32 each  passthrough results.
- `register0_write_index_i`, `register1_write_index_i`  in  4 each  passthrough indices.
- `register_wea_i`, `register_web_i`  in  1 each  passthrough write enables.
- `stall_o`  out  1  upstream must hold its outputs.
- `dmem_address_o`  out  32  Wishbone address.
- `dmem_data_o`  out  16  Wishbone write data.
- `dmem_data_i`  in  16  Wishbone read data.
- `dmem_sel_o`  out  2  byte lanes; bit1 = [15:8].
- `dmem_cyc_o`, `dmem_stb_o`, `dmem_we_o`  out  1 each  Wishbone controls.
- `dmem_ack_i`  in  1  Wishbone acknowledge.
- `valid_o`  out  1  result valid to writeback, one-cycle pulse.
- `load_o`  out  1  `valid_o` carries load data.
- `load_data_o`  out  32  zero-extended load result.
- `reg0_result_o`, `reg1_result_o`, `register0_write_index_o`, `register1_write_index_o`, `register_wea_o`, `register_web_o`  out  passthroughs registered alongside `valid_o`.

Behaviour:
- Reset (`rst_i`=0 at posedge):
  - State → IDLE.
  - All outputs 0, including `stall_o`, `valid_o`, `dmem_cyc_o`, `dmem_stb_o`, `dmem_we_o`.
  - Reset mid-access drops `cyc`/`stb` on that edge. No completion is reported and the in-flight ack is ignored.
- States: IDLE, BEAT0, BEAT1. `stall_o` = (state != IDLE), decoded from the state register.
- IDLE, `valid_i`=0: `valid_o`←0.
- IDLE, `valid_i`=1, no memory op:
  - Passthroughs registered, `valid_o`←1, `load_o`←0 next cycle.
  - Latency 1, throughput 1 per cycle.
- IDLE, `valid_i`=1, memory op:
  - Latch all inputs and `valid_o`←0.
  - Next cycle: `cyc`=`stb`=1, `we`=`mem_wr` (and not `mem_rd`). State→BEAT0.
- Address rule: short/long use `memory_address_i` with bit0 forced to 0. Byte uses the full address.
- Lanes and data, BEAT0:
  - Byte, even address: `sel`=10.
  - Byte, odd address: `sel`=01.
  - Byte store data = {`mem_data_i[7:0]`, `mem_data_i[7:0]`}.
  - Short: `sel`=11, data = `mem_data_i[15:0]`.
  - Long: `sel`=11, data = `mem_data_i[31:16]`.
- BEAT0 without ack: hold all bus signals, stay in BEAT0. No timeout.
- BEAT0 with ack, long:
  - Capture the high half.
  - Next cycle: address+2 (32-bit wrap, 0xFFFFFFFE→0x00000000), data = `mem_data_i[15:0]`, `cyc`/`stb` stay high. State→BEAT1.
- BEAT0 with ack, byte/short; or BEAT1 with ack:
  - Next cycle: `cyc`=`stb`=`we`=0, state→IDLE, `valid_o`=1, `load_o`=`mem_rd`.
  - Load data:
    - Byte: {24'b0, selected lane}.
    - Short: {16'b0, `dmem_data_i`}.
    - Long: {hi, lo}.
    - Stores: 0.
- Load latency = acks + 1 cycles. A new `valid_i` is accepted in the same cycle `valid_o` pulses.
- `valid_i` while `stall_o`=1 is ignored; upstream guarantees a stable hold.
- `load_data_o` and the passthroughs keep their value when `valid_o`=0.

Optional Feature:
- Macro `CPU_MEMORY_ALIGN_CHECK_EN`.
- When defined:
  - Adds output `align_fault_o` (1 bit, reset 0).
  - A short/long access with address bit0=1, or a long access with address bit1=1, starts no bus cycle.
  - The next cycle pulses `valid_o`=1 and `align_fault_o`=1 with `register_wea_o`=`register_web_o`=0, `load_o`=0. State stays IDLE.
- When undefined: no port; address bits are forced to alignment per the address rule above.

Test Plan:
- Zero-wait slave, long store `mem_data_i`=0x12345678 to 0x1000 → beat 0x1000/0x1234, then 0x1002/0x5678, `sel`=11 both. `stall_o` high for 2 cycles, then `valid_o` 1 cycle.
- Long load from 0x2000, slave returns 0xCAFE then 0xBABE with 2 wait states each → `load_data_o`=0xCAFEBABE, `load_o`=1, `stall_o` held throughout.
- Byte load at 0x3001 with `dmem_data_i`=0xA55A → `sel`=01, `load_data_o`=0x0000005A. Byte store 0x7F at 0x3000 → `sel`=10, data 0x7F7F.
- Long load at 0xFFFFFFFE → second beat address 0x00000000.
- Back-to-back non-memory ops for 4 cycles → 4 consecutive `valid_o` pulses with matching `reg0_result_o`, `stall_o`=0 throughout.
- `rst_i`=0 during BEAT1 with ack pending → `cyc`/`stb` 0 next edge, no `valid_o`. With the macro defined, a long load at 0x1002 → `align_fault_o`=1, no `cyc`.

Source files
------------

// File: rtl/cpu_memory.sv
// cpu_memory: memory stage of the mox125 pipeline.
// Takes execute results, performs loads/stores over a 16-bit big-endian
// Wishbone master (32-bit accesses split into two beats) and forwards
// register results to writeback. stall_o holds upstream while a bus
// access is in flight.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   valid_i, mem_rd_i, mem_wr_i, mem_size_i, memory_address_i, mem_data_i
//                           instruction from execute
//   reg*_result_i, register*_write_index_i, register_we*_i
//                           passthroughs to writeback
//   stall_o                 upstream must hold
//   dmem_*                  Wishbone master (sel bit1 = [15:8])
//   valid_o, load_o, load_data_o, passthrough outputs   to writeback
//   align_fault_o           only with CPU_MEMORY_ALIGN_CHECK_EN defined
//
// Optional feature: define CPU_MEMORY_ALIGN_CHECK_EN to reject misaligned
// short/long accesses instead of silently aligning them.
//
// state | meaning
// IDLE  | no bus access, accepting instructions
// BEAT0 | first (or only) bus beat in flight
// BEAT1 | second beat of a long access in flight
module cpu_memory #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] memory_address_i,
  input  logic [31:0]       mem_data_i,
  input  logic [31:0]       reg0_result_i,
  input  logic [31:0]       reg1_result_i,
  input  logic [3:0]        register0_write_index_i,
  input  logic [3:0]        register1_write_index_i,
  input  logic              register_wea_i,
  input  logic              register_web_i,
  output logic              stall_o,
  output logic [ADDR_W-1:0] dmem_address_o,
  output logic [15:0]       dmem_data_o,
  input  logic [15:0]       dmem_data_i,
  output logic [1:0]        dmem_sel_o,
  output logic              dmem_cyc_o,
  output logic              dmem_stb_o,
  output logic              dmem_we_o,
  input  logic              dmem_ack_i,
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
  output logic              align_fault_o,
`endif
  output logic              valid_o,
  output logic              load_o,
  output logic [31:0]       load_data_o,
  output logic [31:0]       reg0_result_o,
  output logic [31:0]       reg1_result_o,
  output logic [3:0]        register0_write_index_o,
  output logic [3:0]        register1_write_index_o,
  output logic              register_wea_o,
  output logic              register_web_o
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t state_q, state_d;

  // Instruction latched at acceptance, replayed to writeback on completion
  logic        is_load_q, is_long_q, is_byte_q, byte_odd_q;
  logic [15:0] wdata_lo_q, hi_q;
  logic [31:0] res0_q, res1_q;
  logic [3:0]  idx0_q, idx1_q;
  logic        wea_q, web_q;

  logic              mem_op, is_long_in, is_byte_in, misalign;
  logic [ADDR_W-1:0] beat0_addr;
  logic [1:0]        beat0_sel;
  logic [15:0]       beat0_data;
  logic [31:0]       done_data;

  assign stall_o = (state_q != IDLE);

  always_comb begin
    mem_op     = mem_rd_i | mem_wr_i;
    is_long_in = mem_size_i[1];
    is_byte_in = (mem_size_i == 2'b00);
    misalign   = 1'b0;
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
    misalign   = !is_byte_in && (memory_address_i[0] || (is_long_in && memory_address_i[1]));
`endif
    beat0_addr = is_byte_in ? memory_address_i : {memory_address_i[ADDR_W-1:1], 1'b0};
    beat0_sel  = 2'b11;
    beat0_data = mem_data_i[15:0];
    if (is_byte_in) begin
      // big-endian: even byte address lives on the high lane
      beat0_sel  = memory_address_i[0] ? 2'b01 : 2'b10;
      beat0_data = {mem_data_i[7:0], mem_data_i[7:0]};
    end else if (is_long_in) begin
      beat0_data = mem_data_i[31:16];
    end
    done_data = 32'h0;
    if (is_load_q) begin
      if (is_byte_q)      done_data = {24'h0, byte_odd_q ? dmem_data_i[7:0] : dmem_data_i[15:8]};
      else if (is_long_q) done_data = {hi_q, dmem_data_i};
      else                done_data = {16'h0, dmem_data_i};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i && mem_op && !misalign) state_d = BEAT0;
      BEAT0:   if (dmem_ack_i) state_d = is_long_q ? BEAT1 : IDLE;
      BEAT1:   if (dmem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dmem_address_o <= '0;
      dmem_data_o <= '0;
      dmem_sel_o <= '0;
      dmem_cyc_o <= 1'b0;
      dmem_stb_o <= 1'b0;
      dmem_we_o <= 1'b0;
      valid_o <= 1'b0;
      load_o <= 1'b0;
      load_data_o <= '0;
      reg0_result_o <= '0;
      reg1_result_o <= '0;
      register0_write_index_o <= '0;
      register1_write_index_o <= '0;
      register_wea_o <= 1'b0;
      register_web_o <= 1'b0;
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
      align_fault_o <= 1'b0;
`endif
      is_load_q <= 1'b0;
      is_long_q <= 1'b0;
      is_byte_q <= 1'b0;
      byte_odd_q <= 1'b0;
      wdata_lo_q <= '0;
      hi_q <= '0;
      res0_q <= '0;
      res1_q <= '0;
      idx0_q <= '0;
      idx1_q <= '0;
      wea_q <= 1'b0;
      web_q <= 1'b0;
    end else begin
      valid_o <= 1'b0;
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
      align_fault_o <= 1'b0;
`endif
      case (state_q)
        IDLE: if (valid_i) begin
          if (!mem_op || misalign) begin
            reg0_result_o <= reg0_result_i;
            reg1_result_o <= reg1_result_i;
            register0_write_index_o <= register0_write_index_i;
            register1_write_index_o <= register1_write_index_i;
            register_wea_o <= register_wea_i && !misalign;
            register_web_o <= register_web_i && !misalign;
            valid_o <= 1'b1;
            load_o <= 1'b0;
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
            align_fault_o <= misalign;
`endif
          end else begin
            is_load_q <= mem_rd_i;
            is_long_q <= is_long_in;
            is_byte_q <= is_byte_in;
            byte_odd_q <= memory_address_i[0];
            wdata_lo_q <= mem_data_i[15:0];
            res0_q <= reg0_result_i;
            res1_q <= reg1_result_i;
            idx0_q <= register0_write_index_i;
            idx1_q <= register1_write_index_i;
            wea_q <= register_wea_i;
            web_q <= register_web_i;
            dmem_address_o <= beat0_addr;
            dmem_sel_o <= beat0_sel;
            dmem_data_o <= beat0_data;
            dmem_cyc_o <= 1'b1;
            dmem_stb_o <= 1'b1;
            dmem_we_o <= mem_wr_i && !mem_rd_i;
          end
        end
        BEAT0, BEAT1: if (dmem_ack_i) begin
          if (state_q == BEAT0 && is_long_q) begin
            hi_q <= dmem_data_i;
            dmem_address_o <= dmem_address_o + ADDR_W'(2);
            dmem_data_o <= wdata_lo_q;
          end else begin
            dmem_cyc_o <= 1'b0;
            dmem_stb_o <= 1'b0;
            dmem_we_o <= 1'b0;
            valid_o <= 1'b1;
            load_o <= is_load_q;
            load_data_o <= done_data;
            reg0_result_o <= res0_q;
            reg1_result_o <= res1_q;
            register0_write_index_o <= idx0_q;
            register1_write_index_o <= idx1_q;
            register_wea_o <= wea_q;
            register_web_o <= web_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
module tb_cpu_memory;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, mem_rd_i, mem_wr_i;
  logic [1:0]  mem_size_i;
  logic [31:0] memory_address_i, mem_data_i, reg0_result_i, reg1_result_i;
  logic [3:0]  register0_write_index_i, register1_write_index_i;
  logic        register_wea_i, register_web_i;
  logic        stall_o;
  logic [31:0] dmem_address_o;
  logic [15:0] dmem_data_o, dmem_data_i;
  logic [1:0]  dmem_sel_o;
  logic        dmem_cyc_o, dmem_stb_o, dmem_we_o, dmem_ack_i;
  logic        valid_o, load_o;
  logic [31:0] load_data_o, reg0_result_o, reg1_result_o;
  logic [3:0]  register0_write_index_o, register1_write_index_o;
  logic        register_wea_o, register_web_o;
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
  logic        align_fault_o;
`endif

  cpu_memory #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i), .memory_address_i(memory_address_i),
    .mem_data_i(mem_data_i), .reg0_result_i(reg0_result_i), .reg1_result_i(reg1_result_i),
    .register0_write_index_i(register0_write_index_i),
    .register1_write_index_i(register1_write_index_i),
    .register_wea_i(register_wea_i), .register_web_i(register_web_i),
    .stall_o(stall_o), .dmem_address_o(dmem_address_o), .dmem_data_o(dmem_data_o),
    .dmem_data_i(dmem_data_i), .dmem_sel_o(dmem_sel_o), .dmem_cyc_o(dmem_cyc_o),
    .dmem_stb_o(dmem_stb_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
    .align_fault_o(align_fault_o),
`endif
    .valid_o(valid_o), .load_o(load_o), .load_data_o(load_data_o),
    .reg0_result_o(reg0_result_o), .reg1_result_o(reg1_result_o),
    .register0_write_index_o(register0_write_index_o),
    .register1_write_index_o(register1_write_index_o),
    .register_wea_o(register_wea_o), .register_web_o(register_web_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        load;
    logic        chk_data;
    logic [31:0] data;
    logic [31:0] r0, r1;
    logic [3:0]  i0, i1;
    logic        wea, web, fault;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pass(input logic [31:0] r0, output exp_t e);
    reg0_result_i = r0;
    reg1_result_i = ~r0;
    register0_write_index_i = r0[3:0];
    register1_write_index_i = r0[7:4];
    register_wea_i = 1'b1;
    register_web_i = r0[8];
    e.load = 1'b0; e.chk_data = 1'b0; e.data = 32'h0;
    e.r0 = r0; e.r1 = ~r0; e.i0 = r0[3:0]; e.i1 = r0[7:4];
    e.wea = 1'b1; e.web = r0[8]; e.fault = 1'b0;
  endtask

  // Scoreboard: every valid_o pulse must match the oldest pushed expectation
  always @(negedge clk_i) begin
    if (rst_i && valid_o) begin
      if (sb_q.size() == 0) check_val("spurious_valid", valid_o, 0);
      else begin
        mon_e = sb_q.pop_front();
        check_val("wb_load", load_o, mon_e.load);
        if (mon_e.chk_data) check_val("wb_load_data", load_data_o, mon_e.data);
        check_val("wb_pass", {reg0_result_o, reg1_result_o},
                  {mon_e.r0, mon_e.r1});
        check_val("wb_idx_we", {register0_write_index_o, register1_write_index_o,
                                register_wea_o, register_web_o},
                  {mon_e.i0, mon_e.i1, mon_e.wea, mon_e.web});
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
        check_val("wb_fault", align_fault_o, mon_e.fault);
`endif
      end
    end
  end

  task automatic do_mem(input string tag, input logic rd, input logic wr,
                        input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input logic [31:0] exp_data);
    exp_t        e;
    int          nb;
    logic [31:0] a0, ea;
    logic [1:0]  sel;
    logic [15:0] wd;
    nb  = size[1] ? 2 : 1;
    a0  = (size == 2'b00) ? addr : {addr[31:1], 1'b0};
    sel = (size == 2'b00) ? (addr[0] ? 2'b01 : 2'b10) : 2'b11;
    set_pass(addr ^ wdata ^ 32'h0000_0135, e);
    e.load = rd; e.chk_data = 1'b1; e.data = exp_data;
    sb_q.push_back(e);
    valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_size_i = size;
    memory_address_i = addr; mem_data_i = wdata;
    step();
    valid_i = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < waits; w++) begin
        check_val({tag, "_wait_hold"}, {stall_o, dmem_cyc_o, dmem_stb_o, valid_o}, 4'b1110);
        step();
      end
      ea = a0 + ((b == 1) ? 32'd2 : 32'd0);
      check_val({tag, "_ctl"}, {stall_o, dmem_cyc_o, dmem_stb_o, dmem_we_o},
                {3'b111, wr & ~rd});
      check_val({tag, "_addr"}, dmem_address_o, ea);
      check_val({tag, "_sel"}, dmem_sel_o, sel);
      if (wr && !rd) begin
        if (size == 2'b00)      wd = {wdata[7:0], wdata[7:0]};
        else if (size == 2'b01) wd = wdata[15:0];
        else                    wd = (b == 0) ? wdata[31:16] : wdata[15:0];
        check_val({tag, "_wdata"}, dmem_data_o, wd);
      end
      dmem_ack_i = 1'b1;
      dmem_data_i = (nb == 2 && b == 0) ? rdata[31:16] : rdata[15:0];
      step();
      dmem_ack_i = 1'b0;
      dmem_data_i = 16'h0;
    end
    check_val({tag, "_done"}, {stall_o, dmem_cyc_o, dmem_stb_o, valid_o}, 4'b0001);
  endtask

  initial begin
    exp_t e;
    rst_i = 1'b0; valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_size_i = 2'b00;
    memory_address_i = 32'h0; mem_data_i = 32'h0; reg0_result_i = 32'h0;
    reg1_result_i = 32'h0; register0_write_index_i = 4'h0; register1_write_index_i = 4'h0;
    register_wea_i = 1'b0; register_web_i = 1'b0; dmem_data_i = 16'h0; dmem_ack_i = 1'b0;
    step(); step();
    check_val("rst_ctl", {stall_o, valid_o, load_o, dmem_cyc_o, dmem_stb_o, dmem_we_o}, 6'b0);
    check_val("rst_bus", {dmem_address_o, dmem_data_o, dmem_sel_o}, 50'h0);
    check_val("rst_wb", {load_data_o, reg0_result_o}, 64'h0);
    rst_i = 1'b1;
    step();
    check_val("idle_no_valid", valid_o, 0);

    do_mem("st_long", 1'b0, 1'b1, 2'b10, 32'h0000_1000, 32'h1234_5678, 32'h0, 0, 32'h0);
    do_mem("ld_long", 1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0, 32'hCAFE_BABE, 2, 32'hCAFE_BABE);
    do_mem("ld_byte_odd", 1'b1, 1'b0, 2'b00, 32'h0000_3001, 32'h0, 32'h0000_A55A, 0, 32'h0000_005A);
    do_mem("ld_byte_even", 1'b1, 1'b0, 2'b00, 32'h0000_3002, 32'h0, 32'h0000_A55A, 1, 32'h0000_00A5);
    do_mem("st_byte", 1'b0, 1'b1, 2'b00, 32'h0000_3000, 32'h0000_007F, 32'h0, 0, 32'h0);
    do_mem("ld_wrap", 1'b1, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 32'h1122_3344, 0, 32'h1122_3344);
    do_mem("ld_rdwr", 1'b1, 1'b1, 2'b01, 32'h0000_5000, 32'hFFFF_FFFF, 32'h0000_8001, 1, 32'h0000_8001);
    do_mem("st_short", 1'b0, 1'b1, 2'b01, 32'h0000_6000, 32'hBEEF_1234, 32'h0, 0, 32'h0);
`ifndef CPU_MEMORY_ALIGN_CHECK_EN
    do_mem("ld_short_odd", 1'b1, 1'b0, 2'b01, 32'h0000_3005, 32'h0, 32'h0000_4321, 0, 32'h0000_4321);
    do_mem("ld_long_mis", 1'b1, 1'b0, 2'b10, 32'h0000_7003, 32'h0, 32'h0102_0304, 0, 32'h0102_0304);
`endif
    mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_pass(32'h0000_0100 + 32'(k * 17), e);
      sb_q.push_back(e);
      valid_i = 1'b1;
      step();
      check_val("nm_valid", valid_o, 1);
      check_val("nm_stall", {stall_o, dmem_cyc_o}, 2'b00);
    end
    valid_i = 1'b0;
    step();
    check_val("nm_idle", valid_o, 0);

    // reset while the second beat's ack is being presented
    set_pass(32'hDEAD_0000, e);
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_size_i = 2'b10; memory_address_i = 32'h0000_4000;
    step();
    valid_i = 1'b0;
    dmem_ack_i = 1'b1; dmem_data_i = 16'h1111;
    step();
    check_val("rst_mid_beat1", {stall_o, dmem_cyc_o, dmem_address_o}, {2'b11, 32'h0000_4002});
    rst_i = 1'b0; dmem_data_i = 16'h2222;
    step();
    check_val("rst_mid_drop", {stall_o, dmem_cyc_o, dmem_stb_o, valid_o}, 4'b0000);
    dmem_ack_i = 1'b0; rst_i = 1'b1;
    step(); step();
    check_val("rst_mid_after", {valid_o, dmem_cyc_o, stall_o}, 3'b000);

`ifdef CPU_MEMORY_ALIGN_CHECK_EN
    set_pass(32'h0000_0A5F, e);
    e.fault = 1'b1; e.wea = 1'b0; e.web = 1'b0;
    sb_q.push_back(e);
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'b10;
    memory_address_i = 32'h0000_1002;
    step();
    valid_i = 1'b0;
    check_val("align_fault", {align_fault_o, valid_o, dmem_cyc_o, stall_o}, 4'b1100);
    step();
    check_val("align_clear", {align_fault_o, valid_o, dmem_cyc_o}, 3'b000);
`endif

    step();
    check_val("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
